// File: rtl/bram_port_arbiter_pkg.sv
// Small helpers shared by the BRAM port arbiter files.
// Holds functions only; every parameter stays local to its module.
package bram_port_arbiter_pkg;

  function automatic int unsigned wrapAdd(input int unsigned base,
                                          input int unsigned offset,
                                          input int unsigned n);
    return (base + offset) % n;
  endfunction

  function automatic int strobeWidth(input int dataWidth);
    return dataWidth / 8;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side and BRAM-side signals of the arbiter, bundled for port lists.
// The slave modport is the arbiter's view; master is the environment's view.
interface bram_port_arbiter_if #(
  parameter int NUM_PORTS       = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 16
);
  import bram_port_arbiter_pkg::*;

  localparam int STRB_W = strobeWidth(DATA_WIDTH);

  logic [NUM_PORTS-1:0]                      req_valid;
  logic [NUM_PORTS-1:0]                      req_ready;
  logic [NUM_PORTS-1:0]                      req_lock;
  logic [NUM_PORTS-1:0][STRB_W-1:0]          req_we;
  logic [NUM_PORTS-1:0][BRAM_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]      req_wrdata;
  logic [NUM_PORTS-1:0]                      rsp_valid;
  logic [DATA_WIDTH-1:0]                     rsp_rddata;

  logic                       bram_en;
  logic [STRB_W-1:0]          bram_we;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0]      bram_wrdata;
  logic [DATA_WIDTH-1:0]      bram_rddata;

  modport slave (
    input  req_valid, req_lock, req_we, req_addr, req_wrdata, bram_rddata,
    output req_ready, rsp_valid, rsp_rddata,
    output bram_en, bram_we, bram_addr, bram_wrdata
  );

  modport master (
    output req_valid, req_lock, req_we, req_addr, req_wrdata, bram_rddata,
    input  req_ready, rsp_valid, rsp_rddata,
    input  bram_en, bram_we, bram_addr, bram_wrdata
  );

endinterface

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin pointer, lock tracking and priority search for the BRAM port.
// Produces a one-hot grant that is forced to zero while rstn is low.
module rr_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_lock,
  output logic [NUM_PORTS-1:0] o_grant
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_UNLOCKED,
    ST_LOCKED
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptrNext;
  logic [IDX_W-1:0]   r_lockIdx;
  logic [IDX_W-1:0]   w_lockIdxNext;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_foundIdx;
  logic               w_found;

  // Search upward from the pointer, wrapping, for the first requesting port.
  always_comb begin
    w_found    = 1'b0;
    w_foundIdx = '0;
    w_cand     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand = IDX_W'(wrapAdd(32'(r_ptr), k, NUM_PORTS));
      if (!w_found && i_req[w_cand]) begin
        w_found    = 1'b1;
        w_foundIdx = w_cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_UNLOCKED;
      r_ptr     <= '0;
      r_lockIdx <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_ptr     <= w_ptrNext;
      r_lockIdx <= w_lockIdxNext;
    end
  end

  // A locked owner keeps the port until it releases lock on a grant or drops valid.
  always_comb begin
    w_stateNext   = r_state;
    w_ptrNext     = r_ptr;
    w_lockIdxNext = r_lockIdx;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_found) begin
          w_ptrNext = IDX_W'(wrapAdd(32'(w_foundIdx), 1, NUM_PORTS));
          if (i_lock[w_foundIdx]) begin
            w_stateNext   = ST_LOCKED;
            w_lockIdxNext = w_foundIdx;
          end
        end
      end
      ST_LOCKED: begin
        if (!i_req[r_lockIdx] || !i_lock[r_lockIdx]) begin
          w_stateNext = ST_UNLOCKED;
          w_ptrNext   = IDX_W'(wrapAdd(32'(r_lockIdx), 1, NUM_PORTS));
        end
      end
      default: w_stateNext = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    o_grant = '0;
    if (rstn) begin
      case (r_state)
        ST_UNLOCKED: if (w_found) o_grant[w_foundIdx] = 1'b1;
        ST_LOCKED:   if (i_req[r_lockIdx]) o_grant[r_lockIdx] = 1'b1;
        default:     o_grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM (read latency 1) among NUM_PORTS requesters.
// Grants are combinational; each grant returns a one-cycle rsp_valid pulse.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 16
) (
  input logic                clk,
  input logic                rstn,
  bram_port_arbiter_if.slave bus
);

  localparam int STRB_W = strobeWidth(DATA_WIDTH);

  logic [NUM_PORTS-1:0]       w_grant;
  logic [NUM_PORTS-1:0]       r_rspValid;
  logic [STRB_W-1:0]          w_bramWe;
  logic [BRAM_ADDR_WIDTH-1:0] w_bramAddr;
  logic [DATA_WIDTH-1:0]      w_bramWrdata;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rrArbiter (
    .clk     (clk),
    .rstn    (rstn),
    .i_req   (bus.req_valid),
    .i_lock  (bus.req_lock),
    .o_grant (w_grant)
  );

  // One-hot AND-OR mux; a zero grant leaves every BRAM control at zero.
  always_comb begin
    w_bramWe     = '0;
    w_bramAddr   = '0;
    w_bramWrdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_bramWe     |= bus.req_we[i]     & {STRB_W{w_grant[i]}};
      w_bramAddr   |= bus.req_addr[i]   & {BRAM_ADDR_WIDTH{w_grant[i]}};
      w_bramWrdata |= bus.req_wrdata[i] & {DATA_WIDTH{w_grant[i]}};
    end
  end

  assign bus.req_ready   = w_grant;
  assign bus.bram_en     = |w_grant;
  assign bus.bram_we     = w_bramWe;
  assign bus.bram_addr   = w_bramAddr;
  assign bus.bram_wrdata = w_bramWrdata;

  // Async clear drops any response that was in flight when reset hit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rspValid <= '0;
    end else begin
      r_rspValid <= w_grant;
    end
  end

  assign bus.rsp_valid  = r_rspValid;
  assign bus.rsp_rddata = bus.bram_rddata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, scored against
// a grant/memory reference model and a behavioural BRAM.
module tb_bram_port_arbiter;

  localparam int NP = 2;
  localparam int DW = 64;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) bus ();

  bram_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  int          refPtr;
  bit          refLocked;
  int          refLockIdx;
  logic [1:0]  prevGrant;
  bit          prevRead;
  logic [63:0] prevData;
  logic [63:0] refMem [0:255];

  logic [63:0] bramMem [0:255];
  logic [63:0] bramRdReg;

  function automatic logic [63:0] byteMask(input logic [7:0] we);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (((we >> b) & 8'h01) != 8'h00) m |= 64'hFF << (8 * b);
    return m;
  endfunction

  // Behavioural BRAM: one-cycle read latency, byte-masked writes.
  assign bus.bram_rddata = bramRdReg;
  always @(posedge clk) begin
    if (bus.bram_en) begin
      bramRdReg <= bramMem[bus.bram_addr[10:3]];
      bramMem[bus.bram_addr[10:3]] <= (bramMem[bus.bram_addr[10:3]] & ~byteMask(bus.bram_we)) |
                                      (bus.bram_wrdata & byteMask(bus.bram_we));
    end
  end

  // Expected grant from the arbitration rules, as a one-hot mask.
  function automatic logic [1:0] modelGrant(input logic [1:0] v);
    logic [1:0] m;
    if (refLocked) return v & 2'(1 << refLockIdx);
    for (int k = 0; k < NP; k++) begin
      m = 2'(1 << ((refPtr + k) % NP));
      if ((v & m) != 2'b00) return m;
    end
    return 2'b00;
  endfunction

  task automatic modelReset();
    refPtr    = 0;
    refLocked = 0;
    prevGrant = 2'b00;
    prevRead  = 0;
  endtask

  // Advance the reference model by one clock using the current inputs, then clock.
  task automatic stepModel(input logic [1:0] g);
    logic [1:0]  lm;
    logic        gi;
    logic [7:0]  w;
    logic [63:0] m;
    gi = g[1];
    if (refLocked) begin
      lm = 2'(1 << refLockIdx);
      if ((bus.req_valid & lm) == 2'b00 || (g != 2'b00 && (bus.req_lock & lm) == 2'b00)) begin
        refLocked = 0;
        refPtr    = (refLockIdx + 1) % NP;
      end
    end else if (g != 2'b00) begin
      refPtr = ((gi ? 1 : 0) + 1) % NP;
      if ((bus.req_lock & g) != 2'b00) begin
        refLocked  = 1;
        refLockIdx = gi ? 1 : 0;
      end
    end
    prevGrant = g;
    prevRead  = 0;
    if (g != 2'b00) begin
      w = bus.req_addr[gi][10:3];
      if (bus.req_we[gi] == 8'h00) begin
        prevRead = 1;
        prevData = refMem[w];
      end else begin
        m = byteMask(bus.req_we[gi]);
        refMem[w] = (refMem[w] & ~m) | (bus.req_wrdata[gi] & m);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [7:0] we0,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [63:0] d0);
    bus.req_valid     = v;
    bus.req_lock      = l;
    bus.req_we[0]     = we0;
    bus.req_we[1]     = 8'h00;
    bus.req_addr[0]   = a0;
    bus.req_addr[1]   = a1;
    bus.req_wrdata[0] = d0;
    bus.req_wrdata[1] = 64'h0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(2'b11, 2'b00, 8'h00, 16'h0010, 16'h0020, 64'h0);
    modelReset();
    @(posedge clk);
    #1;
    for (int s = 0; s < 5; s++) begin
      #3;
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready s=%0d got=%b want=00", s, bus.req_ready); end
      total++; if (bus.bram_en !== 1'b0) begin bad++; $display("FAIL rst_en s=%0d got=%b want=0", s, bus.bram_en); end
      total++; if (bus.bram_we !== 8'h00) begin bad++; $display("FAIL rst_we s=%0d got=%h want=00", s, bus.bram_we); end
      total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp s=%0d got=%b want=00", s, bus.rsp_valid); end
      @(posedge clk);
      #1;
    end
    drive(2'b00, 2'b00, 8'h00, 16'h0, 16'h0, 64'h0);
    rstn = 1'b1;
    for (int s = 0; s < 2; s++) begin
      #3;
      total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL rel_rsp s=%0d got=%b want=00", s, bus.rsp_valid); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rel_ready s=%0d got=%b want=00", s, bus.req_ready); end
      stepModel(2'b00);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    for (int s = 0; s < 7; s++) begin
      if (s < 6) drive(2'b11, 2'b00, 8'h00, 16'h0010, 16'h0020, 64'h0);
      else       drive(2'b00, 2'b00, 8'h00, 16'h0010, 16'h0020, 64'h0);
      #3;
      exp = modelGrant(bus.req_valid);
      if (s < 6) begin
        total++; if (bus.req_ready !== ((s % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_alt s=%0d got=%b", s, bus.req_ready); end
        total++; if (bus.bram_addr !== ((s % 2 == 0) ? 16'h0010 : 16'h0020)) begin bad++; $display("FAIL rr_addr s=%0d got=%h", s, bus.bram_addr); end
      end
      total++; if (bus.req_ready !== exp) begin bad++; $display("FAIL rr_ready s=%0d got=%b want=%b", s, bus.req_ready, exp); end
      total++; if (bus.rsp_valid !== prevGrant) begin bad++; $display("FAIL rr_rsp s=%0d got=%b want=%b", s, bus.rsp_valid, prevGrant); end
      if (prevRead) begin
        total++; if (bus.rsp_rddata !== prevData) begin bad++; $display("FAIL rr_data s=%0d got=%h want=%h", s, bus.rsp_rddata, prevData); end
      end
      stepModel(exp);
    end
  endtask

  task automatic test_write_read();
    logic [1:0]  exp;
    logic [31:0] lowOrig;
    lowOrig = refMem[8][31:0];
    for (int s = 0; s < 3; s++) begin
      case (s)
        0:       drive(2'b01, 2'b00, 8'hF0, 16'h0040, 16'h0, 64'hDEADBEEF_00000000);
        1:       drive(2'b01, 2'b00, 8'h00, 16'h0040, 16'h0, 64'h0);
        default: drive(2'b00, 2'b00, 8'h00, 16'h0, 16'h0, 64'h0);
      endcase
      #3;
      exp = modelGrant(bus.req_valid);
      total++; if (bus.req_ready !== exp) begin bad++; $display("FAIL wr_ready s=%0d got=%b want=%b", s, bus.req_ready, exp); end
      total++; if (bus.bram_we !== ((s == 0) ? 8'hF0 : 8'h00)) begin bad++; $display("FAIL wr_we s=%0d got=%h", s, bus.bram_we); end
      if (s == 0) begin
        total++; if (bus.bram_wrdata !== 64'hDEADBEEF_00000000) begin bad++; $display("FAIL wr_data got=%h", bus.bram_wrdata); end
      end
      if (s == 2) begin
        total++; if (bus.rsp_rddata[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_upper got=%h want=deadbeef", bus.rsp_rddata[63:32]); end
        total++; if (bus.rsp_rddata[31:0] !== lowOrig) begin bad++; $display("FAIL rd_lower got=%h want=%h", bus.rsp_rddata[31:0], lowOrig); end
      end
      total++; if (bus.rsp_valid !== prevGrant) begin bad++; $display("FAIL wr_rsp s=%0d got=%b want=%b", s, bus.rsp_valid, prevGrant); end
      stepModel(exp);
    end
  endtask

  task automatic test_lock();
    logic [1:0] exp;
    logic [1:0] vSeq [0:6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [1:0] lSeq [0:6] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] want [0:6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    for (int s = 0; s < 7; s++) begin
      drive(vSeq[s], lSeq[s], 8'h00, 16'h0008, 16'h0030, 64'h0);
      #3;
      exp = modelGrant(bus.req_valid);
      total++; if (bus.req_ready !== want[s]) begin bad++; $display("FAIL lock_seq s=%0d got=%b want=%b", s, bus.req_ready, want[s]); end
      total++; if (bus.req_ready !== exp) begin bad++; $display("FAIL lock_ready s=%0d got=%b want=%b", s, bus.req_ready, exp); end
      total++; if (bus.rsp_valid !== prevGrant) begin bad++; $display("FAIL lock_rsp s=%0d got=%b want=%b", s, bus.rsp_valid, prevGrant); end
      stepModel(exp);
    end
  endtask

  task automatic test_lock_drop();
    logic [1:0] exp;
    logic [1:0] vSeq [0:3] = '{2'b10, 2'b01, 2'b01, 2'b00};
    logic [1:0] lSeq [0:3] = '{2'b10, 2'b00, 2'b00, 2'b00};
    logic [1:0] want [0:3] = '{2'b10, 2'b00, 2'b01, 2'b00};
    for (int s = 0; s < 4; s++) begin
      drive(vSeq[s], lSeq[s], 8'h00, 16'h0018, 16'h0028, 64'h0);
      #3;
      exp = modelGrant(bus.req_valid);
      total++; if (bus.req_ready !== want[s]) begin bad++; $display("FAIL drop_seq s=%0d got=%b want=%b", s, bus.req_ready, want[s]); end
      total++; if (bus.req_ready !== exp) begin bad++; $display("FAIL drop_ready s=%0d got=%b want=%b", s, bus.req_ready, exp); end
      total++; if (bus.rsp_valid !== prevGrant) begin bad++; $display("FAIL drop_rsp s=%0d got=%b want=%b", s, bus.rsp_valid, prevGrant); end
      stepModel(exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp;
    drive(2'b01, 2'b00, 8'h00, 16'h0018, 16'h0, 64'h0);
    #3;
    exp = modelGrant(bus.req_valid);
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL mid_grant got=%b want=01", bus.req_ready); end
    stepModel(exp);
    rstn = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 16'h0, 16'h0, 64'h0);
    modelReset();
    for (int s = 0; s < 2; s++) begin
      #3;
      total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL mid_rsp s=%0d got=%b want=00", s, bus.rsp_valid); end
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
    drive(2'b11, 2'b00, 8'h00, 16'h0010, 16'h0020, 64'h0);
    #3;
    exp = modelGrant(bus.req_valid);
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL mid_ptr got=%b want=01", bus.req_ready); end
    total++; if (bus.rsp_valid !== 2'b00) begin bad++; $display("FAIL mid_norsp got=%b want=00", bus.rsp_valid); end
    stepModel(exp);
  endtask

  task automatic test_random();
    logic [1:0] exp;
    logic       gi;
    for (int s = 0; s < 400; s++) begin
      bus.req_valid = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      bus.req_lock  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      for (int p = 0; p < NP; p++) begin
        bus.req_we[p]     = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
        bus.req_addr[p]   = 16'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
        bus.req_wrdata[p] = {$urandom, $urandom};
      end
      #3;
      exp = modelGrant(bus.req_valid);
      gi  = exp[1];
      total++; if (bus.req_ready !== exp) begin bad++; $display("FAIL rnd_ready s=%0d got=%b want=%b", s, bus.req_ready, exp); end
      total++; if (bus.bram_en !== (exp != 2'b00)) begin bad++; $display("FAIL rnd_en s=%0d got=%b", s, bus.bram_en); end
      total++; if (bus.bram_we !== ((exp != 2'b00) ? bus.req_we[gi] : 8'h00)) begin bad++; $display("FAIL rnd_we s=%0d got=%h", s, bus.bram_we); end
      if (exp != 2'b00) begin
        total++; if (bus.bram_addr !== bus.req_addr[gi]) begin bad++; $display("FAIL rnd_addr s=%0d got=%h want=%h", s, bus.bram_addr, bus.req_addr[gi]); end
        total++; if (bus.bram_wrdata !== bus.req_wrdata[gi]) begin bad++; $display("FAIL rnd_wdata s=%0d got=%h want=%h", s, bus.bram_wrdata, bus.req_wrdata[gi]); end
      end
      total++; if (bus.rsp_valid !== prevGrant) begin bad++; $display("FAIL rnd_rsp s=%0d got=%b want=%b", s, bus.rsp_valid, prevGrant); end
      if (prevRead) begin
        total++; if (bus.rsp_rddata !== prevData) begin bad++; $display("FAIL rnd_data s=%0d got=%h want=%h", s, bus.rsp_rddata, prevData); end
      end
      stepModel(exp);
    end
  endtask

  initial begin
    logic [63:0] v;
    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom};
      bramMem[i] <= v;
      refMem[i]  = v;
    end
    refLockIdx = 0;
    prevData   = '0;
    test_reset();
    test_round_robin();
    test_write_read();
    test_lock();
    test_lock_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesters sharing one BRAM port (range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, BRAM data width in bits (multiple of 8).
REQ-003 SHALL have parameter BRAM_ADDR_WIDTH, default 16, byte-oriented BRAM address width.
REQ-004 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, NUM_PORTS, per-port request valid.
REQ-007 SHALL have port req_ready, output, NUM_PORTS, per-port grant, at most one bit set.
REQ-008 SHALL have port req_lock, input, NUM_PORTS, per-port request to retain the grant after this access.
REQ-009 SHALL have port req_we, input, NUM_PORTS x DATA_WIDTH/8, per-port byte write strobes; all-zero means read.
REQ-010 SHALL have port req_addr, input, NUM_PORTS x BRAM_ADDR_WIDTH, per-port address.
REQ-011 SHALL have port req_wrdata, input, NUM_PORTS x DATA_WIDTH, per-port write data.
REQ-012 SHALL have port rsp_valid, output, NUM_PORTS, one-cycle completion pulse per port.
REQ-013 SHALL have port rsp_rddata, output, DATA_WIDTH, read data broadcast to all ports.
REQ-014 SHALL have ports bram_en (output, 1), bram_we (output, DATA_WIDTH/8), bram_addr (output, BRAM_ADDR_WIDTH), bram_wrdata (output, DATA_WIDTH), bram_rddata (input, DATA_WIDTH): single-port BRAM, read latency 1.

Function
REQ-015 SHALL accept a request on port i when req_valid[i] and req_ready[i] are both high in the same cycle (a grant).
REQ-016 SHALL compute req_ready combinationally from req_valid, the round-robin pointer and the lock state; req_ready SHALL be all-zero when no req_valid is high.
REQ-017 SHALL, when unlocked, grant the first requesting port at or after the pointer, searching upward modulo NUM_PORTS.
REQ-018 SHALL, on each unlocked grant to port i, set the pointer to (i+1) mod NUM_PORTS; pointer SHALL hold when no grant occurs.
REQ-019 SHALL drive bram_en high exactly in grant cycles, with bram_addr, bram_we, bram_wrdata equal to the granted port's inputs; otherwise bram_we SHALL be zero.
REQ-020 SHALL pulse rsp_valid[i] for exactly one cycle, one cycle after every grant to port i (read or write); no response backpressure exists and requesters SHALL accept it unconditionally.
REQ-021 SHALL drive rsp_rddata = bram_rddata; content is meaningful only in a rsp_valid cycle following a read grant.
REQ-022 SHALL support back-to-back grants every cycle, to the same or different ports, with full throughput of one access per cycle.
REQ-023 SHALL enter LOCKED(i) after a grant to port i with req_lock[i] high; in LOCKED(i) only port i SHALL be granted.
REQ-024 SHALL leave LOCKED(i) to UNLOCKED after a grant to port i with req_lock[i] low, or in any cycle req_valid[i] is low; the pointer SHALL then become (i+1) mod NUM_PORTS.
REQ-025 SHALL treat simultaneous requests from all ports with pointer at port k by granting k, then k+1, ..., wrapping past NUM_PORTS-1 to 0.

Reset
REQ-026 SHALL, while rstn is low, hold req_ready, rsp_valid, bram_en, bram_we at zero, pointer at 0, state UNLOCKED.
REQ-027 SHALL discard a response pending across reset assertion; no rsp_valid pulse SHALL follow reset release.
REQ-028 SHALL release reset synchronously-deasserted; first grant possible in the first clock edge after rstn rises.

Structure
REQ-029 SHALL place no new types in a shared package; parameters are local to the module.
REQ-030 SHALL factor round-robin pointer and priority search into one sub-module rr_arbiter (inputs request vector, lock enable; outputs one-hot grant).

Verification
REQ-031 Reset idle: rstn low 5 cycles, all req_valid=1 -> req_ready=0, bram_en=0, no rsp_valid after release until first grant.
REQ-032 Round-robin: NUM_PORTS=2, both reading continuously, addrs 0x10/0x20 -> grants alternate 0,1,0,1; rsp_valid[0] cycles carry mem[0x10].
REQ-033 Write then read: port 0 writes 0xDEADBEEF_00000000 strobe 0xF0 to 0x40, then reads 0x40 -> rsp_rddata upper 32 bits 0xDEADBEEF, lower bytes unchanged.
REQ-034 Lock: port 1 lock=1 for 3 grants, port 0 requesting -> port 1 granted 3 consecutive cycles plus unlocking grant, then port 0 granted.
REQ-035 Lock drop: port 1 locked, deasserts req_valid -> port 0 granted next cycle.
REQ-036 Reset mid-operation: rstn low in cycle after a read grant -> rsp_valid stays 0, pointer returns to 0.
